// File: rtl/rapids_pkg.sv
// Shared widths, writeback state encoding, write-mask bit positions and ALU opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rapids_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int FLAGS_W = 8;

    // wr_mask bit positions
    localparam int MASK_Y1 = 0;
    localparam int MASK_Y2 = 1;

    // ALU opcodes, shared with decode so both ends agree on one encoding
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WR1  = 2'd1,
        WB_WR2  = 2'd2
    } wb_state_t;

    // Everything captured from the ALU on accept
    typedef struct packed {
        logic [DATA_W-1:0] y1;
        logic [DATA_W-1:0] y2;
        logic [ADDR_W-1:0] dst1;
        logic [ADDR_W-1:0] dst2;
        logic [1:0]        mask;
    } wb_bundle_t;

endpackage

// File: rtl/alu_writeback_capture.sv
// Bundle capture register: holds the accepted ALU result bundle until it retires.
// Latency: 1 cycle (q updates on the edge where load is high).
// Backpressure: none; load is only raised by the owner on an accept.
module wb_capture
    import rapids_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  wb_bundle_t d,
    output wb_bundle_t q
);

    // Load on accept, clear asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: serialises Y1 then Y2 onto one register-file write port; holds compare flags.
// Latency: first write in the cycle after accept; 1 write cycle per enabled mask bit.
// Backpressure: in_ready only in IDLE or while presenting the last pending write; forced low on flush.
module alu_writeback
    import rapids_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  Y1,
    input  logic [DATA_W-1:0]  Y2,
    input  logic [FLAGS_W-1:0] compare_res,
    input  logic [ADDR_W-1:0]  dst1,
    input  logic [ADDR_W-1:0]  dst2,
    input  logic [1:0]         wr_mask,
    input  logic               flags_en,
    input  logic               flush,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [FLAGS_W-1:0] flags,
    output logic               busy
);

    wb_state_t  state;
    wb_state_t  next_state;
    wb_bundle_t cap;
    wb_bundle_t in_bundle;
    logic       accept;
    logic       last_write;

    assign in_bundle = '{y1: Y1, y2: Y2, dst1: dst1, dst2: dst2, mask: wr_mask};

    // WR1 is the last write when Y2 is not enabled; WR2 is always last
    assign last_write = (state == WB_WR2) ||
                        ((state == WB_WR1) && !cap.mask[MASK_Y2]);
    assign in_ready   = rst_n && !flush && ((state == WB_IDLE) || last_write);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != WB_IDLE);

    wb_capture u_capture (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .d     (in_bundle),
        .q     (cap)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flags update only on an accept with flags_en; flush leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (accept && flags_en) begin
            flags <= compare_res;
        end
    end

    // Next state: flush wins, then a fresh accept, then normal sequencing
    always_comb begin
        next_state = WB_IDLE;
        if (flush) begin
            next_state = WB_IDLE;
        end else if (accept) begin
            if (wr_mask[MASK_Y1]) begin
                next_state = WB_WR1;
            end else if (wr_mask[MASK_Y2]) begin
                next_state = WB_WR2;
            end else begin
                next_state = WB_IDLE;
            end
        end else begin
            case (state)
                WB_IDLE: next_state = WB_IDLE;
                WB_WR1:  next_state = cap.mask[MASK_Y2] ? WB_WR2 : WB_IDLE;
                WB_WR2:  next_state = WB_IDLE;
                default: next_state = WB_IDLE;
            endcase
        end
    end

    // Moore write-port decode; address and data are zero when not writing
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state)
            WB_WR1: begin
                rf_we    = 1'b1;
                rf_waddr = cap.dst1;
                rf_wdata = cap.y1;
            end
            WB_WR2: begin
                rf_we    = 1'b1;
                rf_waddr = cap.dst2;
                rf_wdata = cap.y2;
            end
            default: begin
                rf_we    = 1'b0;
                rf_waddr = '0;
                rf_wdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with hand-computed expected values.
module tb_alu_writeback;
    import rapids_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  Y1;
    logic [DATA_W-1:0]  Y2;
    logic [FLAGS_W-1:0] compare_res;
    logic [ADDR_W-1:0]  dst1;
    logic [ADDR_W-1:0]  dst2;
    logic [1:0]         wr_mask;
    logic               flags_en;
    logic               flush;
    logic               rf_we;
    logic [ADDR_W-1:0]  rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [FLAGS_W-1:0] flags;
    logic               busy;

    int vectors;
    int miscompares;

    alu_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Y1          (Y1),
        .Y2          (Y2),
        .compare_res (compare_res),
        .dst1        (dst1),
        .dst2        (dst2),
        .wr_mask     (wr_mask),
        .flags_en    (flags_en),
        .flush       (flush),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .flags       (flags),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, ".we"},    32'(rf_we),    32'(we));
        chk({tag, ".waddr"}, 32'(rf_waddr), addr);
        chk({tag, ".wdata"}, rf_wdata,      data);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        Y1          = '0;
        Y2          = '0;
        compare_res = '0;
        dst1        = '0;
        dst2        = '0;
        wr_mask     = 2'b00;
        flags_en    = 1'b0;
        flush       = 1'b0;

        // Reset state
        #1;
        chk_wr("rst", 1'b0, 32'h0, 32'h0);
        chk("rst.flags", 32'(flags), 32'h0);
        chk("rst.busy",  32'(busy),  32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("idle.in_ready", 32'(in_ready), 32'h1);
        chk("idle.busy",     32'(busy),     32'h0);

        // Dual write, mask 11, flags from compare_res
        in_valid = 1'b1; Y1 = 32'h0000_0005; Y2 = 32'hFFFF_FFFF;
        dst1 = 4'd3; dst2 = 4'd7; wr_mask = 2'b11; flags_en = 1'b1; compare_res = 8'hA5;
        tick();
        in_valid = 1'b0; Y1 = 32'hDEAD_BEEF; Y2 = 32'h0; dst1 = 4'd0; dst2 = 4'd0; flags_en = 1'b0;
        compare_res = 8'h00;
        chk_wr("dual.wr1", 1'b1, 32'd3, 32'h5);
        chk("dual.flags",    32'(flags),    32'hA5);
        chk("dual.busy1",    32'(busy),     32'h1);
        chk("dual.rdy_wr1",  32'(in_ready), 32'h0);
        tick();
        chk_wr("dual.wr2", 1'b1, 32'd7, 32'hFFFF_FFFF);
        chk("dual.rdy_wr2",  32'(in_ready), 32'h1);
        tick();
        chk_wr("dual.done", 1'b0, 32'h0, 32'h0);
        chk("dual.busy_end", 32'(busy),     32'h0);
        chk("dual.flags2",   32'(flags),    32'hA5);

        // Back-to-back single writes, no bubbles
        in_valid = 1'b1; wr_mask = 2'b01; Y1 = 32'd1; dst1 = 4'd1;
        #1;
        chk("b2b.rdy0", 32'(in_ready), 32'h1);
        tick();
        chk_wr("b2b.w1", 1'b1, 32'd1, 32'd1);
        chk("b2b.rdy1", 32'(in_ready), 32'h1);
        Y1 = 32'd2; dst1 = 4'd2;
        tick();
        chk_wr("b2b.w2", 1'b1, 32'd2, 32'd2);
        chk("b2b.rdy2", 32'(in_ready), 32'h1);
        Y1 = 32'd3; dst1 = 4'd3;
        tick();
        chk_wr("b2b.w3", 1'b1, 32'd3, 32'd3);
        chk("b2b.rdy3", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        tick();
        chk_wr("b2b.end", 1'b0, 32'h0, 32'h0);

        // Mask 00: only flags change
        in_valid = 1'b1; wr_mask = 2'b00; flags_en = 1'b1; compare_res = 8'h3C;
        Y1 = 32'h1111_1111; dst1 = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_wr("m00", 1'b0, 32'h0, 32'h0);
            chk("m00.flags", 32'(flags),    32'h3C);
            chk("m00.busy",  32'(busy),     32'h0);
            chk("m00.rdy",   32'(in_ready), 32'h1);
        end
        in_valid = 1'b0; flags_en = 1'b0; compare_res = 8'h00;

        // Flush during WR1: Y1 written, Y2 dropped, flags kept
        in_valid = 1'b1; Y1 = 32'h0000_AAAA; Y2 = 32'h0000_BBBB;
        dst1 = 4'd4; dst2 = 4'd5; wr_mask = 2'b11;
        tick();
        chk_wr("fl.wr1", 1'b1, 32'd4, 32'h0000_AAAA);
        flush = 1'b1; in_valid = 1'b1; wr_mask = 2'b01; dst1 = 4'd6; Y1 = 32'h0000_6666;
        flags_en = 1'b1; compare_res = 8'h99;
        #1;
        chk("fl.rdy", 32'(in_ready), 32'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0; flags_en = 1'b0; compare_res = 8'h00;
        chk_wr("fl.after", 1'b0, 32'h0, 32'h0);
        chk("fl.busy",  32'(busy),  32'h0);
        chk("fl.flags", 32'(flags), 32'h3C);
        tick();
        chk_wr("fl.noy2", 1'b0, 32'h0, 32'h0);

        // Destination collision: both writes, Y2 last
        in_valid = 1'b1; Y1 = 32'h11; Y2 = 32'h22; dst1 = 4'd9; dst2 = 4'd9; wr_mask = 2'b11;
        tick();
        in_valid = 1'b0;
        chk_wr("col.w1", 1'b1, 32'd9, 32'h11);
        tick();
        chk_wr("col.w2", 1'b1, 32'd9, 32'h22);
        tick();
        chk_wr("col.end", 1'b0, 32'h0, 32'h0);

        // Asynchronous reset mid-WR1
        in_valid = 1'b1; Y1 = 32'h1234; Y2 = 32'h5678; dst1 = 4'd2; dst2 = 4'd3;
        wr_mask = 2'b11; flags_en = 1'b1; compare_res = 8'h5A;
        tick();
        in_valid = 1'b0; flags_en = 1'b0; compare_res = 8'h00;
        chk_wr("ar.wr1", 1'b1, 32'd2, 32'h1234);
        chk("ar.flags_pre", 32'(flags), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk_wr("ar.drop", 1'b0, 32'h0, 32'h0);
        chk("ar.flags", 32'(flags), 32'h0);
        chk("ar.busy",  32'(busy),  32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk_wr("ar.post1", 1'b0, 32'h0, 32'h0);
        chk("ar.busy2",  32'(busy),     32'h0);
        chk("ar.rdy",    32'(in_ready), 32'h1);
        tick();
        chk_wr("ar.post2", 1'b0, 32'h0, 32'h0);
        chk("ar.flags2", 32'(flags), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the ALU.
- Accepts one ALU result bundle per handshake: Y1, Y2, the 8-bit compare result, destination indices and a write mask.
- Serialises the two 32-bit results onto the single register-file write port, Y1 first, then Y2.
- Holds the architectural compare-flags register, which feeds branch logic.

Parameters:
- DATA_W, 32, width of each ALU result word.
- ADDR_W, 4, register-file index width.
- FLAGS_W, 8, compare-result / flags width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a valid result bundle.
- in_ready  output  1  stage can accept a bundle this cycle.
- Y1  input  DATA_W  first ALU result.
- Y2  input  DATA_W  second ALU result.
- compare_res  input  FLAGS_W  ALU comparator output.
- dst1  input  ADDR_W  destination index for Y1.
- dst2  input  ADDR_W  destination index for Y2.
- wr_mask  input  2  bit0 writes Y1, bit1 writes Y2.
- flags_en  input  1  update the flags register on accept.
- flush  input  1  synchronous abort of pending writes.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  ADDR_W  register-file write index.
- rf_wdata  output  DATA_W  register-file write data.
- flags  output  FLAGS_W  architectural flags register.
- busy  output  1  writes still pending.

Behaviour:
- Reset and clocking: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, flags 0, busy 0, capture registers 0. in_ready is 1 once rst_n deasserts.
- Reset mid-operation: asserting rst_n low during WR1 or WR2 drops rf_we the same instant. No partial write is completed afterwards.
- States:
  - IDLE: nothing pending.
  - WR1: presenting Y1.
  - WR2: presenting Y2.
- Accept: an accept occurs on the rising edge where in_valid && in_ready. On accept the stage latches Y1, Y2, dst1, dst2 and wr_mask.
- Flags: if flags_en is high on accept, flags <= compare_res at that same edge. Flags never change otherwise, and flush does not revert them.
- State after accept, by mask:
  - mask 01 or 11: next state WR1.
  - mask 10: next state WR2.
  - mask 00: stay in IDLE. Only flags may change, and a new accept is possible every cycle.
- WR1: rf_we=1, rf_waddr=dst1 (latched), rf_wdata=Y1 (latched). Next state is WR2 if mask bit1, otherwise IDLE.
- WR2: rf_we=1, rf_waddr=dst2, rf_wdata=Y2. Next state is IDLE.
- Output timing: rf_we, rf_waddr and rf_wdata are decoded from registered state only (Moore). When rf_we=0, rf_waddr and rf_wdata are 0.
- Latency: the first write appears in the cycle after accept.
  - Single-write bundle: 1 cycle.
  - Dual-write bundle: 2 cycles.
- in_ready = (state==IDLE) || (state is presenting the last pending write). This allows back-to-back single-write bundles at one per cycle.
- in_ready never depends combinationally on in_valid.
- Pipelined accept: an accept during the last write loads the new bundle at the same edge the old write retires, with no bubble.
- busy = (state != IDLE).
- Register-index collision: if dst1 == dst2 with mask 11, both writes are issued and Y2 lands last. No merging is performed.
- Flush:
  - When flush is high at an edge, the next state is IDLE and pending writes are discarded.
  - The write presented in the flush cycle is still performed, because rf_we is already asserted that cycle.
  - in_ready is forced 0 while flush is high, so no accept occurs in a flush cycle.
- Upstream data: the stage places no stability requirement on upstream data after accept, because all data is captured.

Decomposition:
- Shared package (rapids_pkg):
  - Width constants DATA_W, ADDR_W, FLAGS_W.
  - Writeback state enum {WB_IDLE, WB_WR1, WB_WR2}.
  - wr_mask bit positions.
  - The ALU op localparams (ADD/SUB/...), so decode and writeback share one source.
- One sub-module: wb_capture, the bundle capture register with load enable and async clear.
- The FSM and output decode stay in alu_writeback.

Test Plan:
- Reset, then accept Y1=0x0000_0005, Y2=0xFFFF_FFFF, dst1=3, dst2=7, mask 11, flags_en=1, compare_res=0xA5:
  - next cycle rf_we=1, waddr=3, wdata=0x5;
  - following cycle waddr=7, wdata=0xFFFFFFFF;
  - then rf_we=0;
  - flags=0xA5 from the accept edge.
- Back-to-back mask 01 bundles (Y1=1, 2, 3 to regs 1, 2, 3) with in_valid held high:
  - in_ready stays 1;
  - three consecutive write cycles with waddr 1, 2, 3 and no bubbles.
- mask 00, flags_en=1, compare_res=0x3C: no rf_we ever, flags=0x3C, busy stays 0, in_ready stays 1.
- Dual bundle with flush asserted in the WR1 cycle:
  - Y1 write occurs;
  - no Y2 write;
  - state IDLE next;
  - in_ready=0 during flush;
  - flags unchanged.
- dst1=dst2=9, mask 11, Y1=0x11, Y2=0x22: two writes to reg 9, the last with wdata=0x22.
- rst_n pulsed low mid-WR1: rf_we drops immediately (asynchronous); after release state is IDLE, flags=0, and no write of Y2.
